// File: rtl/conv2_mac_engine_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : conv2_mac_engine_pkg
//  Description : Shared constants for the conv2 MAC engine. It holds the
//                default layer geometry, the data widths and the FSM state
//                encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
package conv2_mac_engine_pkg;

  // Default layer geometry for the conv2 stage.
  localparam int c_co     = 3;   // output channels
  localparam int c_ci     = 3;   // input channels
  localparam int c_kx     = 5;   // kernel width
  localparam int c_ky     = 5;   // kernel height
  localparam int c_i_bw   = 8;   // unsigned activation width
  localparam int c_w_bw   = 8;   // signed weight width
  localparam int c_acc_bw = 24;  // signed accumulator width

  // FSM state encodings.
  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_calc = 2'd1;
  localparam logic [1:0] c_st_done = 2'd2;

endpackage : conv2_mac_engine_pkg
`default_nettype wire

// File: rtl/conv2_dot_product.sv
`default_nettype none
// ============================================================================
//  Module      : conv2_dot_product
//  Description : Combinational dot product of one input window with one
//                output-channel weight slice. Each unsigned activation is
//                zero-extended and each signed weight is sign-extended to the
//                full product width. Every product is then sign-extended to
//                ACC_BW, and all of them are summed without saturation.
//  Ports       : i_window  N*I_BW   flat activations, element i at [i*I_BW]
//                i_weight  N*W_BW   flat weights, element i at [i*W_BW]
//                o_sum     ACC_BW   signed sum of products
//  Revision    : 1.0 - initial release
// ============================================================================
module conv2_dot_product #(
  parameter int N      = 75,
  parameter int I_BW   = 8,
  parameter int W_BW   = 8,
  parameter int ACC_BW = 24
) (
  input  logic [N*I_BW-1:0] i_window,
  input  logic [N*W_BW-1:0] i_weight,
  output logic [ACC_BW-1:0] o_sum
);

  localparam int PROD_W = I_BW + 1 + W_BW;

  logic [PROD_W-1:0] w_act  [N];
  logic [PROD_W-1:0] w_wgt  [N];
  logic [PROD_W-1:0] w_prod [N];

  // Both operands are widened to PROD_W before the multiply. The truncated
  // two's-complement product then equals the exact signed product.
  genvar g;
  generate
    for (g = 0; g < N; g++) begin : g_mul
      assign w_act[g]  = {{(W_BW + 1){1'b0}}, i_window[g*I_BW +: I_BW]};
      assign w_wgt[g]  = {{(I_BW + 1){i_weight[g*W_BW + W_BW - 1]}},
                          i_weight[g*W_BW +: W_BW]};
      assign w_prod[g] = $signed(w_act[g]) * $signed(w_wgt[g]);
    end
  endgenerate

  // Sign-extend each product to ACC_BW and reduce. The tool can rebalance
  // this chain into a tree.
  always_comb begin
    o_sum = '0;
    for (int i = 0; i < N; i++) begin
      o_sum = o_sum + {{(ACC_BW - PROD_W){w_prod[i][PROD_W-1]}}, w_prod[i]};
    end
  end

endmodule : conv2_dot_product
`default_nettype wire

// File: rtl/conv2_mac_engine.sv
`default_nettype none
// ============================================================================
//  Module      : conv2_mac_engine
//  Description : Conv2 compute stage. The engine accepts one CI x KY x KX
//                window per handshake and computes CO dot products, one output
//                channel per cycle, on a single shared dot-product unit. It
//                presents all CO results as one registered flat word with a
//                valid/ready handshake. ReLU is applied optionally.
//  Ports       : clk, reset_n        clock / async active-low reset
//                i_weight            CO*CI*KY*KX*W_BW flat weights (read in CALC)
//                i_valid/o_in_ready  input window handshake
//                i_window            CI*KY*KX*I_BW flat window
//                o_valid/i_ready     result handshake
//                o_data              CO*ACC_BW, channel co at [co*ACC_BW]
//  Revision    : 1.0 - initial release
// ============================================================================
module conv2_mac_engine
  import conv2_mac_engine_pkg::*;
#(
  parameter int CO     = c_co,
  parameter int CI     = c_ci,
  parameter int KX     = c_kx,
  parameter int KY     = c_ky,
  parameter int I_BW   = c_i_bw,
  parameter int W_BW   = c_w_bw,
  parameter int ACC_BW = c_acc_bw,
  parameter int RELU   = 1
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [CO*CI*KY*KX*W_BW-1:0]   i_weight,
  input  logic                          i_valid,
  output logic                          o_in_ready,
  input  logic [CI*KY*KX*I_BW-1:0]      i_window,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic [CO*ACC_BW-1:0]          o_data
);

  localparam int N       = CI * KY * KX;
  localparam int WIN_W   = N * I_BW;
  localparam int SLICE_W = N * W_BW;
  localparam int CNT_W   = (CO > 1) ? $clog2(CO) : 1;
  localparam logic [CNT_W-1:0] c_last_co = CNT_W'(CO - 1);

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   co_cnt_q, co_cnt_d;
  logic [WIN_W-1:0]   window_q, window_d;
  logic [ACC_BW-1:0]  result_q [CO];
  logic [ACC_BW-1:0]  result_d [CO];
  logic [SLICE_W-1:0] w_weight_slice;
  logic [ACC_BW-1:0]  w_dot_sum;
  logic               w_accept;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= c_st_idle;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_st_idle: if (i_valid)                state_d = c_st_calc;
      c_st_calc: if (co_cnt_q == c_last_co)  state_d = c_st_done;
      c_st_done: if (i_ready)                state_d = c_st_idle;
      default:                               state_d = c_st_idle;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs. Both handshake signals are decoded from the state, so they
  // can never be high in the same cycle.
  // --------------------------------------------------------------------------
  always_comb begin
    o_in_ready = (state_q == c_st_idle);
    o_valid    = (state_q == c_st_done);
  end

  assign w_accept = o_in_ready && i_valid;

  // --------------------------------------------------------------------------
  // Weight-slice mux. The slice is zero outside CALC, so the ROM bus is only
  // observed while a channel is being computed.
  // --------------------------------------------------------------------------
  always_comb begin
    w_weight_slice = '0;
    if (state_q == c_st_calc) begin
      for (int co = 0; co < CO; co++) begin
        if (co_cnt_q == CNT_W'(co)) begin
          w_weight_slice = i_weight[co*SLICE_W +: SLICE_W];
        end
      end
    end
  end

  conv2_dot_product #(
    .N      (N),
    .I_BW   (I_BW),
    .W_BW   (W_BW),
    .ACC_BW (ACC_BW)
  ) u_dot (
    .i_window (window_q),
    .i_weight (w_weight_slice),
    .o_sum    (w_dot_sum)
  );

  // --------------------------------------------------------------------------
  // Datapath next-state: window capture, channel counter, result writeback
  // --------------------------------------------------------------------------
  always_comb begin
    window_d = window_q;
    co_cnt_d = co_cnt_q;
    result_d = result_q;
    if (w_accept) begin
      window_d = i_window;
      co_cnt_d = '0;
    end
    if (state_q == c_st_calc) begin
      for (int co = 0; co < CO; co++) begin
        if (co_cnt_q == CNT_W'(co)) begin
          result_d[co] = w_dot_sum;
        end
      end
      co_cnt_d = (co_cnt_q == c_last_co) ? '0 : co_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      window_q <= '0;
      co_cnt_q <= '0;
      for (int co = 0; co < CO; co++) begin
        result_q[co] <= '0;
      end
    end else begin
      window_q <= window_d;
      co_cnt_q <= co_cnt_d;
      for (int co = 0; co < CO; co++) begin
        result_q[co] <= result_d[co];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output word. The result registers are stable through any stall, so the
  // optional clamp after them keeps o_data stable as well.
  // --------------------------------------------------------------------------
  genvar g;
  generate
    for (g = 0; g < CO; g++) begin : g_out
      assign o_data[g*ACC_BW +: ACC_BW] =
        ((RELU != 0) && result_q[g][ACC_BW-1]) ? '0 : result_q[g];
    end
  endgenerate

endmodule : conv2_mac_engine
`default_nettype wire
